cm0_dap_dp_cdc: RTL and testbench

DP-side end of the DP↔AP clock-domain-crossing handshake. It launches the transfer request, address, direction and write data from the DP clock domain toward an AP, and synchronises the AP acknowledge back. It captures AP read data and error status and reports completion to the DP core. It sits between the DP register/transfer logic and each AP's CDC front end, and is the initiator of the four-phase req/ack protocol.

---
 rtl/cm0_dap_dp_cdc.sv | 160 ++++++++++++++++
 tb/tb_cm0_dap_dp_cdc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_dap_dp_cdc.sv
// rtl/cm0_dap_dp_cdc.sv - DP-side initiator of the DP/AP four-phase req/ack clock-domain crossing
// Optional feature macro: DAP_DP_CDC_SYNC3_EN selects a 3-flop ack synchroniser (2 flops when undefined).
module cm0_dap_dp_cdc #(
  parameter int PRESENT = 1
) (
  input  logic        dclk,
  input  logic        dpreset,
  input  logic        dp_xfer_i,
  input  logic        dp_rnw_i,
  input  logic [3:0]  dp_regaddr_i,
  input  logic [31:0] dp_data_i,
  output logic        dp_req_dp_o,
  output logic        dp_rnw_o,
  output logic [3:0]  dp_regaddr_o,
  output logic [31:0] dp_data_o,
  input  logic        ap_ack_ap_i,
  input  logic [31:0] ap_data_i,
  input  logic        ap_err_i,
  output logic        dp_busy_o,
  output logic        dp_done_o,
  output logic [31:0] dp_rdata_o,
  output logic        dp_err_o,
  output logic        dp_ovr_o,
  input  logic        dp_ovr_clr_i,
  input  logic        SE
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_REQ    = 2'd2,
    ST_ACKLO  = 2'd3
  } state_t;

  if (PRESENT != 0) begin : g_present

`ifdef DAP_DP_CDC_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

    logic [SYNC_DEPTH-1:0] ack_sync;
    logic                  ack_s;

    state_t state, state_nxt;
    logic   launch, capture, done_nxt, ovr_set;

    logic        req_q, rnw_q, done_q, err_q, ovr_q;
    logic [3:0]  regaddr_q;
    logic [31:0] data_q, rdata_q;

    // Ack synchroniser, deliberately not reset so SETTLE sees an ack the AP still holds;
    // in scan mode every stage loads the ack pin directly.
    always_ff @(posedge dclk) begin
      if (SE) ack_sync <= {SYNC_DEPTH{ap_ack_ap_i}};
      else    ack_sync <= {ack_sync[SYNC_DEPTH-2:0], ap_ack_ap_i};
    end

    assign ack_s = ack_sync[SYNC_DEPTH-1];

    // Handshake state register; reset parks in SETTLE until any lingering ack clears.
    always_ff @(posedge dclk) begin
      if (dpreset) state <= ST_SETTLE;
      else         state <= state_nxt;
    end

    // Next-state and one-cycle control strobes for the datapath.
    always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      capture   = 1'b0;
      done_nxt  = 1'b0;
      ovr_set   = 1'b0;
      case (state)
        ST_SETTLE: begin
          ovr_set = dp_xfer_i;
          if (!ack_s) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (dp_xfer_i) begin
            launch    = 1'b1;
            state_nxt = ST_REQ;
          end
        end
        ST_REQ: begin
          ovr_set = dp_xfer_i;
          if (ack_s) begin
            capture   = 1'b1;
            state_nxt = ST_ACKLO;
          end
        end
        ST_ACKLO: begin
          ovr_set = dp_xfer_i;
          if (!ack_s) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_SETTLE;
      endcase
    end

    // Launch, capture, done and overrun flops; launch values move only on IDLE->REQ.
    always_ff @(posedge dclk) begin
      if (dpreset) begin
        req_q     <= 1'b0;
        rnw_q     <= 1'b0;
        regaddr_q <= 4'h0;
        data_q    <= 32'h0;
        done_q    <= 1'b0;
        rdata_q   <= 32'h0;
        err_q     <= 1'b0;
        ovr_q     <= 1'b0;
      end else begin
        req_q  <= (state_nxt == ST_REQ);
        done_q <= done_nxt;
        if (launch) begin
          rnw_q     <= dp_rnw_i;
          regaddr_q <= dp_regaddr_i;
          data_q    <= dp_data_i;
        end
        if (capture) begin
          err_q <= ap_err_i;
          if (rnw_q) rdata_q <= ap_data_i;
        end
        if (ovr_set)           ovr_q <= 1'b1;
        else if (dp_ovr_clr_i) ovr_q <= 1'b0;
      end
    end

    assign dp_req_dp_o  = req_q;
    assign dp_rnw_o     = rnw_q;
    assign dp_regaddr_o = regaddr_q;
    assign dp_data_o    = data_q;
    assign dp_busy_o    = (state != ST_IDLE);
    assign dp_done_o    = done_q;
    assign dp_rdata_o   = rdata_q;
    assign dp_err_o     = err_q;
    assign dp_ovr_o     = ovr_q;

  end else begin : g_absent

    logic unused_inputs;
    assign unused_inputs = ^{dclk, dpreset, dp_xfer_i, dp_rnw_i, dp_regaddr_i, dp_data_i,
                             ap_ack_ap_i, ap_data_i, ap_err_i, dp_ovr_clr_i, SE};

    assign dp_req_dp_o  = 1'b0;
    assign dp_rnw_o     = 1'b0;
    assign dp_regaddr_o = 4'h0;
    assign dp_data_o    = 32'h0;
    assign dp_busy_o    = 1'b0;
    assign dp_done_o    = 1'b0;
    assign dp_rdata_o   = 32'h0;
    assign dp_err_o     = 1'b0;
    assign dp_ovr_o     = 1'b0;

  end

endmodule

// File: tb/tb_cm0_dap_dp_cdc.sv
// tb/tb_cm0_dap_dp_cdc.sv - scoreboard bench for cm0_dap_dp_cdc with a behavioural loopback AP
`timescale 1ns/1ps
module tb_cm0_dap_dp_cdc;

`ifdef DAP_DP_CDC_SYNC3_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 2;
`endif

  logic        dclk = 1'b0;
  logic        dpreset = 1'b1;
  logic        dp_xfer_i = 1'b0;
  logic        dp_rnw_i = 1'b0;
  logic [3:0]  dp_regaddr_i = 4'h0;
  logic [31:0] dp_data_i = 32'h0;
  logic        ap_ack_ap_i = 1'b0;
  logic [31:0] ap_data_i = 32'h0;
  logic        ap_err_i = 1'b0;
  logic        dp_ovr_clr_i = 1'b0;
  logic        SE = 1'b0;

  logic        dp_req_dp_o, dp_rnw_o, dp_busy_o, dp_done_o, dp_err_o, dp_ovr_o;
  logic [3:0]  dp_regaddr_o;
  logic [31:0] dp_data_o, dp_rdata_o;

  logic        a_req, a_rnw, a_busy, a_done, a_err, a_ovr;
  logic [3:0]  a_addr;
  logic [31:0] a_data, a_rdata;
  logic        absent_any;

  always #5 dclk = ~dclk;

  cm0_dap_dp_cdc u_dut (
    .dclk(dclk), .dpreset(dpreset), .dp_xfer_i(dp_xfer_i), .dp_rnw_i(dp_rnw_i),
    .dp_regaddr_i(dp_regaddr_i), .dp_data_i(dp_data_i), .dp_req_dp_o(dp_req_dp_o),
    .dp_rnw_o(dp_rnw_o), .dp_regaddr_o(dp_regaddr_o), .dp_data_o(dp_data_o),
    .ap_ack_ap_i(ap_ack_ap_i), .ap_data_i(ap_data_i), .ap_err_i(ap_err_i),
    .dp_busy_o(dp_busy_o), .dp_done_o(dp_done_o), .dp_rdata_o(dp_rdata_o),
    .dp_err_o(dp_err_o), .dp_ovr_o(dp_ovr_o), .dp_ovr_clr_i(dp_ovr_clr_i), .SE(SE)
  );

  cm0_dap_dp_cdc #(.PRESENT(0)) u_absent (
    .dclk(dclk), .dpreset(dpreset), .dp_xfer_i(dp_xfer_i), .dp_rnw_i(dp_rnw_i),
    .dp_regaddr_i(dp_regaddr_i), .dp_data_i(dp_data_i), .dp_req_dp_o(a_req),
    .dp_rnw_o(a_rnw), .dp_regaddr_o(a_addr), .dp_data_o(a_data),
    .ap_ack_ap_i(ap_ack_ap_i), .ap_data_i(ap_data_i), .ap_err_i(ap_err_i),
    .dp_busy_o(a_busy), .dp_done_o(a_done), .dp_rdata_o(a_rdata),
    .dp_err_o(a_err), .dp_ovr_o(a_ovr), .dp_ovr_clr_i(dp_ovr_clr_i), .SE(SE)
  );

  assign absent_any = |{a_req, a_rnw, a_addr, a_data, a_busy, a_done, a_rdata, a_err, a_ovr};

  typedef struct packed {
    logic        rnw;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = 32'h0;

  // AP model controls
  int          ap_delay = 4;
  int          ap_drop = 2;
  bit          ap_hold = 1'b0;
  bit          meas_en = 1'b0;
  logic [31:0] ap_rdata_v = 32'h0;
  logic        ap_err_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loopback AP: acks ap_delay cycles after seeing req, drops ack ap_drop cycles after req falls.
  initial begin
    int lat;
    forever begin
      @(negedge dclk);
      if (dp_req_dp_o === 1'b1 && ap_ack_ap_i == 1'b0) begin
        repeat (ap_delay) @(posedge dclk);
        #1;
        ap_data_i   = ap_rdata_v;
        ap_err_i    = ap_err_v;
        ap_ack_ap_i = 1'b1;
        lat = 0;
        do begin
          @(posedge dclk);
          lat++;
          @(negedge dclk);
        end while (dp_req_dp_o && lat < 60);
        if (meas_en) chk("req_fall_latency", 64'(lat), 64'(SYNC_DEPTH + 1));
        while (ap_hold) @(posedge dclk);
        repeat (ap_drop) @(posedge dclk);
        #1;
        ap_ack_ap_i = 1'b0;
        ap_data_i   = 32'h0F0F0F0F;
        ap_err_i    = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done pulse pops one expected completion.
  always @(negedge dclk) begin
    if (dp_done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_rnw",   64'(dp_rnw_o),     64'(mon_e.rnw));
        chk("done_addr",  64'(dp_regaddr_o), 64'(mon_e.addr));
        chk("done_wdata", 64'(dp_data_o),    64'(mon_e.data));
        chk("done_rdata", 64'(dp_rdata_o),   64'(mon_e.rdata));
        chk("done_err",   64'(dp_err_o),     64'(mon_e.err));
        chk("done_busy",  64'(dp_busy_o),    64'd0);
        chk("absent_out", 64'(absent_any),   64'd0);
      end
    end
  end

  // Launch flops must hold across any cycle in which req or ack was high (reset excepted).
  logic        pw = 1'b0;
  logic        pr = 1'b1;
  logic [36:0] pl = '0;
  always @(negedge dclk) begin
    if (pw && !pr) chk("launch_stable", 64'({dp_rnw_o, dp_regaddr_o, dp_data_o}), 64'(pl));
    pw = dp_req_dp_o | ap_ack_ap_i;
    pr = dpreset;
    pl = {dp_rnw_o, dp_regaddr_o, dp_data_o};
  end

  task automatic issue(input logic rnw, input logic [3:0] addr, input logic [31:0] data,
                       input logic [31:0] ap_rd, input logic ap_er, input bit track);
    exp_t e;
    @(posedge dclk);
    #1;
    dp_xfer_i    = 1'b1;
    dp_rnw_i     = rnw;
    dp_regaddr_i = addr;
    dp_data_i    = data;
    ap_rdata_v   = ap_rd;
    ap_err_v     = ap_er;
    if (track) begin
      if (rnw) m_rdata = ap_rd;
      e.rnw   = rnw;
      e.addr  = addr;
      e.data  = data;
      e.rdata = m_rdata;
      e.err   = ap_er;
      exp_q.push_back(e);
    end
    @(posedge dclk);
    #1;
    dp_xfer_i    = 1'b0;
    dp_regaddr_i = ~addr;
    dp_data_i    = ~data;
    dp_rnw_i     = ~rnw;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 200) begin
      @(negedge dclk);
      if (dp_done_o) break;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles at %0t", $time);
    end
  endtask

  initial begin
    int n;
    repeat (4) @(posedge dclk);
    @(negedge dclk);
    chk("rst_req",   64'(dp_req_dp_o),  64'd0);
    chk("rst_rnw",   64'(dp_rnw_o),     64'd0);
    chk("rst_addr",  64'(dp_regaddr_o), 64'd0);
    chk("rst_wdata", 64'(dp_data_o),    64'd0);
    chk("rst_busy",  64'(dp_busy_o),    64'd1);
    chk("rst_done",  64'(dp_done_o),    64'd0);
    chk("rst_rdata", 64'(dp_rdata_o),   64'd0);
    chk("rst_err",   64'(dp_err_o),     64'd0);
    chk("rst_ovr",   64'(dp_ovr_o),     64'd0);
    @(posedge dclk);
    #1;
    dpreset = 1'b0;
    repeat (2) @(negedge dclk);
    chk("settle_exit_busy", 64'(dp_busy_o), 64'd0);

    // Read with error
    meas_en = 1'b1;
    issue(1'b1, 4'h5, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1);
    wait_done();

    // Write: rdata keeps the previous read value
    issue(1'b0, 4'hC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1);
    @(negedge dclk);
    chk("wr_req_high", 64'(dp_req_dp_o), 64'd1);
    chk("wr_busy",     64'(dp_busy_o),   64'd1);
    chk("wr_wdata",    64'(dp_data_o),   64'hDEAD_BEEF);
    chk("absent_busy", 64'(absent_any),  64'd0);
    wait_done();

    // Overrun: xfer during REQ together with clr, set wins
    issue(1'b1, 4'h3, 32'h1111_1111, 32'hA5A5_A5A5, 1'b0, 1'b1);
    dp_xfer_i    = 1'b1;
    dp_regaddr_i = 4'h9;
    dp_ovr_clr_i = 1'b1;
    @(posedge dclk);
    #1;
    dp_xfer_i    = 1'b0;
    dp_ovr_clr_i = 1'b0;
    @(negedge dclk);
    chk("ovr_set",       64'(dp_ovr_o),     64'd1);
    chk("ovr_addr_held", 64'(dp_regaddr_o), 64'h3);
    wait_done();
    chk("ovr_sticky", 64'(dp_ovr_o), 64'd1);
    @(posedge dclk);
    #1;
    dp_ovr_clr_i = 1'b1;
    @(posedge dclk);
    #1;
    dp_ovr_clr_i = 1'b0;
    @(negedge dclk);
    chk("ovr_cleared", 64'(dp_ovr_o), 64'd0);

    // Back-to-back: each xfer lands the cycle after the previous done
    issue(1'b0, 4'h1, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
    wait_done();
    issue(1'b1, 4'h2, 32'h0, 32'h5566_7788, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 4'hF, 32'hFFFF_0000, 32'h0, 1'b1, 1'b1);
    wait_done();
    chk("b2b_no_ovr", 64'(dp_ovr_o), 64'd0);

    // Reset while in REQ with the AP holding ack high
    meas_en = 1'b0;
    ap_hold = 1'b1;
    issue(1'b1, 4'h7, 32'h0, 32'h7777_7777, 1'b1, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge dclk);
      if (ap_ack_ap_i) break;
      n++;
    end
    if (n >= 50) chk("ack_rise_timeout", 64'(ap_ack_ap_i), 64'd1);
    @(posedge dclk);
    #1;
    dpreset = 1'b1;
    @(posedge dclk);
    #1;
    dpreset = 1'b0;
    m_rdata = 32'h0;
    @(negedge dclk);
    chk("mid_rst_req",   64'(dp_req_dp_o), 64'd0);
    chk("mid_rst_busy",  64'(dp_busy_o),   64'd1);
    chk("mid_rst_done",  64'(dp_done_o),   64'd0);
    chk("mid_rst_rdata", 64'(dp_rdata_o),  64'd0);
    repeat (4) @(negedge dclk);
    chk("settle_hold_busy", 64'(dp_busy_o), 64'd1);
    @(posedge dclk);
    #1;
    ap_hold = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge dclk);
      if (!ap_ack_ap_i) break;
      n++;
    end
    if (n >= 50) chk("ack_fall_timeout", 64'(ap_ack_ap_i), 64'd0);
    n = 0;
    do begin
      @(posedge dclk);
      n++;
      @(negedge dclk);
    end while (dp_busy_o && n < 50);
    chk("settle_exit_latency", 64'(n), 64'(SYNC_DEPTH + 1));

    // New transfer accepted after the settle
    meas_en = 1'b1;
    issue(1'b0, 4'hA, 32'h0BAD_CAFE, 32'h0, 1'b0, 1'b1);
    wait_done();

    repeat (5) @(posedge dclk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("absent_end",  64'(absent_any),   64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
